uart_cmd_responder: RTL and testbench

- Target-side end of the two-byte UART command link.
- Receives a command frame pair on `rx` and decodes write or read.
- Writes: drives a single-cycle write strobe to the local register bank.
- Reads: fetches the addressed byte and transmits it back on `tx` after a turnaround gap.
- Sits between the board UART pins and the register bank, opposite the command initiator.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_byte_tx.sv | 58 +++++
 rtl/uart_cmd_responder.sv | 201 ++++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the two-byte UART command link (responder and initiator).
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned ADDR_W      = 7;
    localparam int unsigned RW_BIT      = 7;

    // ST_TX covers start/data/parity/stop; uart_byte_tx sequences the individual bits.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RX_START,
        ST_RX_DATA,
        ST_RX_PAR,
        ST_RX_STOP,
        ST_WAIT_B2,
        ST_EXEC,
        ST_TURN,
        ST_TX
    } state_e;

    function automatic logic odd_par(input logic [UART_DATA_W-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Serialises one byte as start, 8 data bits LSB first, odd parity, stop; BR clocks per bit.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned BR = 434
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [UART_DATA_W-1:0] data,
    output logic                   tx,
    output logic                   done
);

    localparam int unsigned BR_W  = $clog2(BR);
    localparam int unsigned SHF_W = UART_DATA_W + 2;

    logic             active_q;
    logic [BR_W-1:0]  br_cnt_q;
    logic [3:0]       bit_q;
    logic [SHF_W-1:0] shift_q;

    // bit_q 0 is the start bit; the shift register holds data, parity and stop behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            br_cnt_q <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
            tx       <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!active_q) begin
                if (start) begin
                    active_q <= 1'b1;
                    tx       <= 1'b0;
                    br_cnt_q <= '0;
                    bit_q    <= '0;
                    shift_q  <= {1'b1, odd_par(data), data};
                end
            end else if (br_cnt_q == BR_W'(BR - 1)) begin
                br_cnt_q <= '0;
                if (bit_q == 4'd10) begin
                    active_q <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    bit_q   <= bit_q + 4'd1;
                    tx      <= shift_q[0];
                    shift_q <= {1'b1, shift_q[SHF_W-1:1]};
                end
            end else begin
                br_cnt_q <= br_cnt_q + BR_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Target end of the two-byte UART command link: receives write/read commands,
// strobes the register bank and returns read data after a turnaround gap.
module uart_cmd_responder
    import uart_pkg::*;
#(
    parameter int unsigned BR      = 434,
    parameter int unsigned TURN    = 200,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    output logic                   tx,
    output logic [ADDR_W-1:0]      reg_addr,
    output logic [UART_DATA_W-1:0] reg_wdata,
    output logic                   reg_wr_en,
    output logic                   reg_rd_en,
    input  logic [UART_DATA_W-1:0] reg_rdata,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int unsigned HALF    = BR / 2;
    localparam int unsigned MAX_A   = (TIMEOUT > TURN) ? TIMEOUT : TURN;
    localparam int unsigned CNT_MAX = (MAX_A > BR) ? MAX_A : BR;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic                   rx_s1, rx_s2, rx_s3;
    logic                   fall_c;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   par_q, par_d;
    logic [UART_DATA_W-1:0] cmd_hi_q, cmd_hi_d;
    logic                   got_b1_q, got_b1_d;
    logic [UART_DATA_W-1:0] wdata_d;
    logic [UART_DATA_W-1:0] rdata_q, rdata_d;
    logic                   wr_en_d, rd_en_d, perr_d, ferr_d;
    logic                   tx_start_c, tx_done;
    logic                   mid_c, bit_end_c;

    assign fall_c    = rx_s3 & ~rx_s2;
    assign mid_c     = (cnt_q == CNT_W'(HALF));
    assign bit_end_c = (cnt_q == CNT_W'(BR - 1));
    assign reg_addr  = cmd_hi_q[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_s3      <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            cmd_hi_q   <= '0;
            got_b1_q   <= 1'b0;
            reg_wdata  <= '0;
            rdata_q    <= '0;
            reg_wr_en  <= 1'b0;
            reg_rd_en  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_s3      <= rx_s2;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            cmd_hi_q   <= cmd_hi_d;
            got_b1_q   <= got_b1_d;
            reg_wdata  <= wdata_d;
            rdata_q    <= rdata_d;
            reg_wr_en  <= wr_en_d;
            reg_rd_en  <= rd_en_d;
            parity_err <= perr_d;
            frame_err  <= ferr_d;
            busy       <= (state_d != ST_IDLE);
        end
    end

    // Next state and datapath; rx is only watched in IDLE, WAIT_B2 and the RX states
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        cmd_hi_d   = cmd_hi_q;
        got_b1_d   = got_b1_q;
        wdata_d    = reg_wdata;
        rdata_d    = rdata_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        tx_start_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                got_b1_d = 1'b0;
                if (fall_c) state_d = ST_RX_START;
            end
            ST_WAIT_B2: begin
                if (fall_c) begin
                    state_d = ST_RX_START;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    got_b1_d = 1'b0;
                end
            end
            ST_RX_START: begin
                if (mid_c && rx_s2) begin
                    state_d = got_b1_q ? ST_WAIT_B2 : ST_IDLE;
                    cnt_d   = '0;
                end else if (bit_end_c) begin
                    state_d = ST_RX_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_RX_DATA: begin
                if (mid_c) shift_d = {rx_s2, shift_q[UART_DATA_W-1:1]};
                if (bit_end_c) begin
                    cnt_d = '0;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_RX_PAR;
                end
            end
            ST_RX_PAR: begin
                if (mid_c) par_d = rx_s2;
                if (bit_end_c) begin
                    cnt_d   = '0;
                    state_d = ST_RX_STOP;
                end
            end
            ST_RX_STOP: begin
                if (mid_c) begin
                    cnt_d  = '0;
                    perr_d = (par_q != odd_par(shift_q));
                    ferr_d = ~rx_s2;
                    if (perr_d || ferr_d) begin
                        state_d  = ST_IDLE;
                        got_b1_d = 1'b0;
                    end else if (!got_b1_q) begin
                        cmd_hi_d = shift_q;
                        got_b1_d = 1'b1;
                        state_d  = ST_WAIT_B2;
                    end else begin
                        wdata_d = shift_q;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                cnt_d    = '0;
                got_b1_d = 1'b0;
                if (cmd_hi_q[RW_BIT]) begin
                    wr_en_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    rd_en_d = 1'b1;
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                // read data arrives the cycle after the registered strobe
                if (cnt_q == CNT_W'(1)) rdata_d = reg_rdata;
                if (cnt_q == CNT_W'(TURN)) begin
                    tx_start_c = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_TX;
                end
            end
            ST_TX: begin
                cnt_d = '0;
                if (tx_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    uart_byte_tx #(.BR(BR)) u_byte_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tx_start_c),
        .data  (rdata_q),
        .tx    (tx),
        .done  (tx_done)
    );

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with shortened bit/turn/timeout constants.
module tb_uart_cmd_responder;

    localparam int unsigned BR      = 16;
    localparam int unsigned TURN    = 20;
    localparam int unsigned TIMEOUT = 600;
    localparam int unsigned HALF    = BR / 2;
    // 2-FF sync + edge register, half a bit to the stop sample, then 1 or 2 cycles to the pulse
    localparam int ERR_LAT = HALF + 4;
    localparam int STB_LAT = HALF + 5;

    logic       clk, rst_n, rx, tx;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata, reg_rdata, rdata_src;
    logic       reg_wr_en, reg_rd_en, parity_err, frame_err, busy;

    int total = 0, bad = 0;
    int cyc = 0;

    uart_cmd_responder #(.BR(BR), .TURN(TURN), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .tx         (tx),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_wr_en  (reg_wr_en),
        .reg_rd_en  (reg_rd_en),
        .reg_rdata  (reg_rdata),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register bank read port: data valid exactly one cycle after the strobe
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) reg_rdata <= 8'h00;
        else        reg_rdata <= reg_rd_en ? rdata_src : 8'h00;
    end

    int wr_cnt = 0, rd_cnt = 0, pe_cnt = 0, fe_cnt = 0;
    int both_cnt = 0, long_cnt = 0, txlow_cnt = 0;
    int wr_cyc = 0, rd_cyc = 0, pe_cyc = 0, fe_cyc = 0;
    logic [6:0] wr_addr = '0, rd_addr = '0;
    logic [7:0] wr_data = '0;
    logic prev_wr = 1'b0, prev_rd = 1'b0, prev_pe = 1'b0, prev_fe = 1'b0;

    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_cnt  <= wr_cnt + 1;
            wr_cyc  <= cyc;
            wr_addr <= reg_addr;
            wr_data <= reg_wdata;
        end
        if (reg_rd_en) begin
            rd_cnt  <= rd_cnt + 1;
            rd_cyc  <= cyc;
            rd_addr <= reg_addr;
        end
        if (parity_err) begin
            pe_cnt <= pe_cnt + 1;
            pe_cyc <= cyc;
        end
        if (frame_err) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
        if (reg_wr_en && reg_rd_en) both_cnt <= both_cnt + 1;
        if ((reg_wr_en && prev_wr) || (reg_rd_en && prev_rd) ||
            (parity_err && prev_pe) || (frame_err && prev_fe))
            long_cnt <= long_cnt + 1;
        if (!tx) txlow_cnt <= txlow_cnt + 1;
        prev_wr <= reg_wr_en;
        prev_rd <= reg_rd_en;
        prev_pe <= parity_err;
        prev_fe <= frame_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic flip, input logic bad_stop,
                             output int stop_cyc);
        logic [10:0] fr;
        fr = {~bad_stop, (~^d) ^ flip, d, 1'b0};
        stop_cyc = 0;
        for (int k = 0; k < 11; k++) begin
            rx = fr[k];
            if (k == 10) stop_cyc = cyc;
            repeat (BR) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic send_cmd(input logic [7:0] b1, input logic [7:0] b2, output int stop_cyc);
        int s1;
        send_byte(b1, 1'b0, 1'b0, s1);
        send_byte(b2, 1'b0, 1'b0, stop_cyc);
    endtask

    // Checks the response frame bit by bit at mid-bit, starting from the recorded read strobe
    task automatic check_response(input logic [7:0] d);
        logic [10:0] fr;
        int t0;
        t0 = rd_cyc;
        fr = {1'b1, ~^d, d, 1'b0};
        for (int i = 0; i < 1000 && cyc < t0 + int'(TURN); i++) @(negedge clk);
        check("tx_turn_high", 32'(tx), 32'd1);
        @(negedge clk);
        check("tx_start_edge", 32'(tx), 32'd0);
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            check($sformatf("rsp_bit%0d", k), 32'(tx), 32'(fr[k]));
            repeat (BR) @(negedge clk);
        end
        for (int i = 0; i < 4 * int'(BR) && busy; i++) @(negedge clk);
        check("rsp_busy_low", 32'(busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s1, b_wr, b_rd, b_pe, b_fe, b_tx, t0;
        rx        = 1'b1;
        rst_n     = 1'b0;
        rdata_src = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_en", 32'(reg_wr_en), 32'd0);
        check("rst_rd_en", 32'(reg_rd_en), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_wdata", 32'(reg_wdata), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // write 0x05 <= 0x3C
        #1;
        b_wr = wr_cnt; b_rd = rd_cnt; b_tx = txlow_cnt;
        send_cmd(8'h85, 8'h3C, s);
        repeat (4) @(negedge clk); #1;
        check("wr_count", wr_cnt - b_wr, 1);
        check("wr_addr", 32'(wr_addr), 32'h05);
        check("wr_data", 32'(wr_data), 32'h3C);
        check("wr_latency", wr_cyc, s + STB_LAT);
        check("wr_no_rd", rd_cnt - b_rd, 0);
        check("wr_tx_idle", txlow_cnt - b_tx, 0);
        check("wr_busy_low", 32'(busy), 32'd0);

        // read 0x05 returns 0xA7
        rdata_src = 8'hA7;
        b_wr = wr_cnt; b_rd = rd_cnt;
        send_cmd(8'h05, 8'h00, s);
        #1;
        check("rd_count", rd_cnt - b_rd, 1);
        check("rd_addr", 32'(rd_addr), 32'h05);
        check("rd_latency", rd_cyc, s + STB_LAT);
        check("rd_no_wr", wr_cnt - b_wr, 0);
        check_response(8'hA7);
        repeat (4) @(negedge clk); #1;

        // byte 2 with bad parity
        b_wr = wr_cnt; b_rd = rd_cnt; b_pe = pe_cnt; b_fe = fe_cnt;
        send_byte(8'h85, 1'b0, 1'b0, s1);
        send_byte(8'h3C, 1'b1, 1'b0, s);
        check("pe_busy_low", 32'(busy), 32'd0);
        repeat (4) @(negedge clk); #1;
        check("pe_count", pe_cnt - b_pe, 1);
        check("pe_latency", pe_cyc, s + ERR_LAT);
        check("pe_no_ferr", fe_cnt - b_fe, 0);
        check("pe_no_strobe", (wr_cnt - b_wr) + (rd_cnt - b_rd), 0);

        // byte 1 with stop bit low, then a clean write
        b_pe = pe_cnt; b_fe = fe_cnt;
        send_byte(8'h81, 1'b0, 1'b1, s);
        repeat (4) @(negedge clk); #1;
        check("fe_count", fe_cnt - b_fe, 1);
        check("fe_latency", fe_cyc, s + ERR_LAT);
        check("fe_no_perr", pe_cnt - b_pe, 0);
        check("fe_busy_low", 32'(busy), 32'd0);
        b_wr = wr_cnt;
        send_cmd(8'h81, 8'hFF, s);
        repeat (4) @(negedge clk); #1;
        check("fe_next_wr_count", wr_cnt - b_wr, 1);
        check("fe_next_wr_addr", 32'(wr_addr), 32'h01);
        check("fe_next_wr_data", 32'(wr_data), 32'hFF);

        // low glitch shorter than half a bit
        b_wr = wr_cnt; b_rd = rd_cnt; b_pe = pe_cnt; b_fe = fe_cnt;
        rx = 1'b0;
        repeat (HALF - 3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BR) @(negedge clk); #1;
        check("glitch_no_events", (wr_cnt - b_wr) + (rd_cnt - b_rd) + (pe_cnt - b_pe) + (fe_cnt - b_fe), 0);
        check("glitch_busy_low", 32'(busy), 32'd0);

        // byte 1 then silence past the timeout; next byte starts a fresh command
        send_byte(8'h85, 1'b0, 1'b0, s);
        repeat (TIMEOUT + 10) @(negedge clk); #1;
        check("to_busy_low", 32'(busy), 32'd0);
        b_wr = wr_cnt;
        send_cmd(8'h82, 8'h11, s);
        repeat (4) @(negedge clk); #1;
        check("to_wr_count", wr_cnt - b_wr, 1);
        check("to_wr_addr", 32'(wr_addr), 32'h02);
        check("to_wr_data", 32'(wr_data), 32'h11);

        // reset in the middle of the response data bits
        rdata_src = 8'hA7;
        send_cmd(8'h05, 8'h00, s);
        #1;
        t0 = rd_cyc;
        for (int i = 0; i < 1000 && cyc < t0 + int'(TURN) + 1 + 4 * int'(BR) + int'(HALF); i++)
            @(negedge clk);
        check("rst_mid_tx_low", 32'(tx), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_high", 32'(tx), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk); #1;
        rdata_src = 8'h5A;
        b_rd = rd_cnt;
        send_cmd(8'h22, 8'h00, s);
        #1;
        check("post_rst_rd_count", rd_cnt - b_rd, 1);
        check("post_rst_rd_addr", 32'(rd_addr), 32'h22);
        check_response(8'h5A);

        #1;
        check("strobes_overlap", both_cnt, 0);
        check("pulse_too_long", long_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
